uart_console: RTL
=================

// Module: uart_console
// PURPOSE
//  Memory-mapped console between the core's data-store path and uart_tx. Byte stores to
//  TXDATA are queued in a FIFO; a drain FSM hands bytes one at a time to uart_tx via the
//  uart_tx_en/uart_tx_busy handshake. This lets firmware print without polling per bit.
//  The status register is readable on the load path.
// PARAMETERS
//  DEPTH      16             FIFO entries, power of two, 2..256
//  BASE_ADDR  32'h0000_1000  byte address of TXDATA; STATUS = +4, OVFCNT = +8
// PORTS
//  clk           in   1   system clock, all state on posedge
//  rst           in   1   synchronous, active-high reset
//  wr_en         in   1   core store strobe (memwrite)
//  rd_en         in   1   core load strobe (memread)
//  addr          in   32  store/load byte address (alu_result)
//  wdata         in   32  store data (rs2value); only [7:0] used
//  rdata         out  32  load data, combinational from addr; 0 when unmapped or !rd_en
//  hit           out  1   addr matches any console register (for write_data mux)
//  uart_tx_data  out  8   byte to uart_tx
//  uart_tx_en    out  1   one-cycle start pulse to uart_tx
//  uart_tx_busy  in   1   uart_tx busy flag
// BEHAVIOUR
//  Reset: FIFO empty, count 0, FSM IDLE, uart_tx_en=0, uart_tx_data=0, OVFCNT=0.
//  Push: wr_en && addr==BASE_ADDR -> wdata[7:0] written at tail next edge, count+1.
//   Push while full is dropped unless a pop happens in the same cycle (then accepted).
//  STATUS read: [0] full, [1] empty, [2] FSM!=IDLE, [3] uart_tx_busy, [15:8] count, rest 0.
//  Stores to STATUS/OVFCNT are ignored; loads of TXDATA return 0.
//  Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
//  Drain FSM:
//   IDLE  : !empty && !uart_tx_busy -> LOAD
//   LOAD  : pop head into uart_tx_data, count-1 -> SEND
//   SEND  : uart_tx_en=1 for exactly this cycle -> WSTART
//   WSTART: wait uart_tx_busy=1 -> WDONE; after 4 cycles without busy -> IDLE (byte lost)
//   WDONE : wait uart_tx_busy=0 -> IDLE
//  Latency: first byte into empty idle FIFO -> uart_tx_en high 3 cycles after store edge.
//  Back-to-back bytes: next LOAD no earlier than cycle after busy falls.
//  uart_tx_data is held stable from LOAD until the next LOAD.
//  Reset mid-transfer: FIFO flushed, FSM IDLE next edge; an in-flight uart_tx frame completes
//   on its own (uart_tx is reset separately by the core).
// CONFIGURATION
//  CONSOLE_OVFCNT_EN defined: OVFCNT (+8) is a 16-bit saturating count of dropped pushes,
//   readable in rdata[15:0]; STATUS[4] is a sticky overflow flag, cleared only by rst.
//  Not defined: no counter, no flag; OVFCNT reads 0, STATUS[4]=0, drops are silent.
// STRUCTURE
//  console_pkg: register offsets (OFF_TXDATA, OFF_STATUS, OFF_OVFCNT), STATUS bit indices,
//   FSM state enum (IDLE, LOAD, SEND, WSTART, WDONE), WSTART timeout constant (4).
//  Sub-module sync_fifo #(WIDTH=8, DEPTH): push/pop/full/empty/count, same-cycle push+pop
//   when full allowed. uart_console holds address decode, status mux, drain FSM, OVFCNT.
// TESTING
//  1 Store 0x41 to BASE_ADDR, uart_tx model busy 10 cycles -> one uart_tx_en pulse, data 0x41,
//    STATUS empty=1 and bit2=0 after busy falls.
//  2 Store "HELLO" back-to-back -> 5 pulses in order 48 45 4C 4C 4F, never en while busy,
//    STATUS[15:8] reads 4 right after the 5th store's edge (one already popped).
//  3 Busy held high, 17 stores with DEPTH=16 -> full=1, 17th dropped; with
//    CONSOLE_OVFCNT_EN, OVFCNT=1 and STATUS[4]=1; without, OVFCNT reads 0.
//  4 Full FIFO, FSM in LOAD with a store in the same cycle -> store accepted, count stays 16.
//  5 Assert rst while 3 bytes queued and in WDONE -> next cycle empty=1, en=0, state IDLE,
//    no further pulses.
//  6 uart_tx model never raises busy -> FSM returns to IDLE 4 cycles after SEND, next byte sent.

Source files
------------

// File: rtl/console_pkg.sv
// Shared register map, STATUS bit positions and drain FSM encoding for uart_console.
package console_pkg;

    localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFF_OVFCNT = 32'h0000_0008;

    localparam int ST_FULL   = 0;
    localparam int ST_EMPTY  = 1;
    localparam int ST_ACTIVE = 2;
    localparam int ST_TXBUSY = 3;
    localparam int ST_OVF    = 4;
    localparam int ST_COUNT  = 8;

    // Cycles spent in WSTART waiting for uart_tx to report busy before the byte is abandoned.
    localparam int WSTART_TIMEOUT = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SEND   = 3'd2,
        WSTART = 3'd3,
        WDONE  = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read port; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module sync_fifo
    import console_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pop_data_reg <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            // Read data is registered on pop and then held until the next pop.
            if (pop_ok) begin
                rd_ptr_reg   <= rd_ptr_reg + AW'(1);
                pop_data_reg <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign pop_data = pop_data_reg;
    assign count    = count_reg;

endmodule

// File: rtl/uart_console.sv
// Memory-mapped console: TXDATA stores are queued and drained to uart_tx one byte at a time.
// Define CONSOLE_OVFCNT_EN to add the dropped-push counter (OVFCNT) and sticky STATUS overflow flag.
module uart_console
    import console_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_en,
    input  logic        uart_tx_busy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(WSTART_TIMEOUT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(WSTART_TIMEOUT - 1);

    logic          sel_tx;
    logic          sel_status;
    logic          sel_ovf;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic [31:0]   status;
    logic [15:0]   ovf_cnt;
    logic          ovf_flag;
    logic          unused_wdata;

    state_t        state_reg;
    state_t        state_next;
    logic [TW-1:0] timer_reg;
    logic [TW-1:0] timer_next;

    assign sel_tx     = (addr == BASE_ADDR + OFF_TXDATA);
    assign sel_status = (addr == BASE_ADDR + OFF_STATUS);
    assign sel_ovf    = (addr == BASE_ADDR + OFF_OVFCNT);
    assign hit        = sel_tx || sel_status || sel_ovf;

    assign push         = wr_en && sel_tx;
    assign pop          = (state_reg == LOAD);
    assign unused_wdata = ^wdata[31:8];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (wdata[7:0]),
        .pop       (pop),
        .pop_data  (uart_tx_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= timer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        timer_next = timer_reg;
        uart_tx_en = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = SEND;
            end
            SEND: begin
                uart_tx_en = 1'b1;
                timer_next = '0;
                state_next = WSTART;
            end
            WSTART: begin
                // A transmitter that never acknowledges costs this byte but must not wedge the queue.
                if (uart_tx_busy) begin
                    state_next = WDONE;
                end else if (timer_reg == TIMER_LAST) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            WDONE: begin
                if (!uart_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

`ifdef CONSOLE_OVFCNT_EN
    logic        drop;
    logic [15:0] ovf_cnt_reg;
    logic        ovf_flag_reg;

    assign drop = push && full && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_cnt_reg  <= '0;
            ovf_flag_reg <= 1'b0;
        end else if (drop) begin
            if (ovf_cnt_reg != 16'hFFFF) begin
                ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
            end
            ovf_flag_reg <= 1'b1;
        end
    end

    assign ovf_cnt  = ovf_cnt_reg;
    assign ovf_flag = ovf_flag_reg;
`else
    assign ovf_cnt  = '0;
    assign ovf_flag = 1'b0;
`endif

    // Count field starts at bit 8; only DEPTH=256 needs its ninth bit (bit 16).
    always_comb begin
        status                  = '0;
        status[ST_FULL]         = full;
        status[ST_EMPTY]        = empty;
        status[ST_ACTIVE]       = (state_reg != IDLE);
        status[ST_TXBUSY]       = uart_tx_busy;
        status[ST_OVF]          = ovf_flag;
        status[ST_COUNT +: CW]  = count;
    end

    always_comb begin
        rdata = '0;
        if (rd_en) begin
            if (sel_status) begin
                rdata = status;
            end else if (sel_ovf) begin
                rdata = {16'h0000, ovf_cnt};
            end
        end
    end

endmodule
